tpu_matrix_loader: RTL and testbench

- Sequencer that takes an input word stream and writes one data tile and one weight tile (each ARRAY_SIZE x ARRAY_SIZE) into the tpuv1 input buffer over its write_addr/data_in/write_en port.
- Then raises tpu_start and waits for completion.
- Replaces hand-driven buffer loading with a parametrised, handshaked block that sits between the host/DMA side and tpuv1.
- Adds two features: an optional per-row weight column reversal, and a completion timeout.

---
 rtl/tpu_matrix_loader.sv | 156 +++++++++++++++
 tb/tb_tpu_matrix_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_matrix_loader.sv
// Streams one data tile and one weight tile into the tpuv1 input buffer,
// then starts the array and waits for completion, with an optional timeout.
module tpu_matrix_loader #(
    parameter int DATA_W      = 16,
    parameter int ARRAY_SIZE  = 2,
    parameter int ADDR_W      = 10,
    parameter int DATA_BASE   = 0,
    parameter int WEIGHT_BASE = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_go,
    input  logic              cfg_rev_w,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    output logic              tpu_start,
    input  logic              tpu_done,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
);

    localparam int N     = ARRAY_SIZE * ARRAY_SIZE;
    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam int CW    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_D,
        LOAD_W,
        FLUSH,
        RUN,
        FIN
    } state_t;

    state_t          state;
    logic            rev_q;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   row;
    logic [CW-1:0]   col;
    logic [TW-1:0]   timer;
    logic            accept;
    logic [CW-1:0]   col_eff;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] w_addr;

    assign in_ready = (state == LOAD_D) || (state == LOAD_W);
    assign busy     = (state != IDLE);
    assign accept   = in_valid & in_ready;

    // Buffer addresses wrap at ADDR_W bits; reversal mirrors the column within a row.
    always_comb begin
        col_eff = rev_q ? (CW'(ARRAY_SIZE - 1) - col) : col;
        d_addr  = ADDR_W'(DATA_BASE) + ADDR_W'(idx);
        w_addr  = ADDR_W'(WEIGHT_BASE) + ADDR_W'(row) * ADDR_W'(ARRAY_SIZE)
                  + ADDR_W'(col_eff);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rev_q       <= 1'b0;
            idx         <= '0;
            row         <= '0;
            col         <= '0;
            timer       <= '0;
            write_addr  <= '0;
            write_data  <= '0;
            write_en    <= 1'b0;
            tpu_start   <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            write_en    <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_go) begin
                        state <= LOAD_D;
                        rev_q <= cfg_rev_w;
                        idx   <= '0;
                        row   <= '0;
                        col   <= '0;
                        timer <= '0;
                    end
                end
                LOAD_D: begin
                    if (accept) begin
                        write_en   <= 1'b1;
                        write_addr <= d_addr;
                        write_data <= in_data;
                        if (idx == IW'(N - 1)) begin
                            state <= LOAD_W;
                            idx   <= '0;
                            row   <= '0;
                            col   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_W: begin
                    if (accept) begin
                        write_en   <= 1'b1;
                        write_addr <= w_addr;
                        write_data <= in_data;
                        if (col == CW'(ARRAY_SIZE - 1)) begin
                            col <= '0;
                            if (row == CW'(ARRAY_SIZE - 1)) begin
                                state <= FLUSH;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                // The last weight write is on the bus during this cycle.
                FLUSH: begin
                    state     <= RUN;
                    tpu_start <= 1'b1;
                end
                // Completion is checked before the timeout so a coincident done wins.
                RUN: begin
                    if (tpu_done) begin
                        state     <= FIN;
                        tpu_start <= 1'b0;
                        done      <= 1'b1;
                    end else if ((TIMEOUT != 0) && (timer == TW'(TLAST))) begin
                        state       <= IDLE;
                        tpu_start   <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_matrix_loader.sv
// Table-driven and randomized checks of tpu_matrix_loader against a tile-level
// address/data model and the completion/timeout rules.
module tb_tpu_matrix_loader;

    localparam int DATA_W      = 16;
    localparam int ARRAY_SIZE  = 2;
    localparam int ADDR_W      = 10;
    localparam int DATA_BASE   = 0;
    localparam int WEIGHT_BASE = 16;
    localparam int TIMEOUT     = 8;
    localparam int N           = ARRAY_SIZE * ARRAY_SIZE;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_go;
    logic              cfg_rev_w;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              write_en;
    logic              tpu_start;
    logic              tpu_done;
    logic              busy;
    logic              done;
    logic              err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit rev;
        int gap;
        bit fixed;
        int done_at;
        int exp_start;
        bit exp_done;
        bit exp_to;
    } vec_t;

    vec_t vecs[6];

    tpu_matrix_loader #(
        .DATA_W(DATA_W), .ARRAY_SIZE(ARRAY_SIZE), .ADDR_W(ADDR_W),
        .DATA_BASE(DATA_BASE), .WEIGHT_BASE(WEIGHT_BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .cfg_go(cfg_go), .cfg_rev_w(cfg_rev_w),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
        .tpu_start(tpu_start), .tpu_done(tpu_done), .busy(busy),
        .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full go/load/run sequence; outputs are sampled and inputs driven on negedges.
    task automatic apply_stimulus(input vec_t v);
        logic [DATA_W-1:0] words[2*N];
        logic [ADDR_W-1:0] exp_addr[2*N];
        int beat, pend, cyc, k, start_cnt, c_eff;
        bit pend_v;
        for (int i = 0; i < 2*N; i++)
            words[i] = v.fixed ? ((i < N) ? DATA_W'(i + 1) : DATA_W'(16 + i - N + 1))
                               : DATA_W'($urandom);
        for (int i = 0; i < N; i++)
            exp_addr[i] = ADDR_W'(DATA_BASE + i);
        for (int r = 0; r < ARRAY_SIZE; r++)
            for (int c = 0; c < ARRAY_SIZE; c++) begin
                c_eff = v.rev ? (ARRAY_SIZE - 1 - c) : c;
                exp_addr[N + r*ARRAY_SIZE + c] = ADDR_W'(WEIGHT_BASE + r*ARRAY_SIZE + c_eff);
            end

        @(negedge clk);
        check_output("idle_busy", busy, 0);
        cfg_go = 1'b1;
        cfg_rev_w = v.rev;
        @(negedge clk);
        cfg_go = 1'b0;
        cfg_rev_w = ~v.rev;
        beat = 0; pend = 0; pend_v = 1'b0; cyc = 0;
        while (beat < 2*N && cyc < 400) begin
            check_output("load_ready", in_ready, 1);
            check_output("load_busy", busy, 1);
            check_output("write_en", write_en, pend_v);
            if (pend_v) begin
                check_output("write_addr", write_addr, exp_addr[pend]);
                check_output("write_data", write_data, words[pend]);
            end
            case (v.gap)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? words[beat] : DATA_W'($urandom);
            pend_v = in_valid;
            pend = beat;
            if (in_valid) beat++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 400) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL load_bound: got %0d beats, expected %0d", beat, 2*N);
        end

        check_output("flush_ready", in_ready, 0);
        check_output("flush_start", tpu_start, 0);
        check_output("write_en_last", write_en, pend_v);
        check_output("write_addr_last", write_addr, exp_addr[pend]);
        check_output("write_data_last", write_data, words[pend]);
        in_valid = 1'b1;
        in_data = DATA_W'($urandom);
        tpu_done = 1'b0;

        start_cnt = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (tpu_start !== 1'b1) break;
            start_cnt++;
            check_output("run_no_write", write_en, 0);
            check_output("run_ready", in_ready, 0);
            tpu_done = (k == v.done_at);
        end
        tpu_done = 1'b0;
        in_valid = 1'b0;
        check_output("start_cycles", start_cnt, v.exp_start);
        check_output("done_pulse", done, v.exp_done);
        check_output("timeout_pulse", err_timeout, v.exp_to);
        check_output("end_busy", busy, v.exp_done);
        @(negedge clk);
        check_output("done_after", done, 0);
        check_output("timeout_after", err_timeout, 0);
        check_output("idle_busy_after", busy, 0);
        check_output("start_after", tpu_start, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t rv;
        vecs[0] = '{1'b0, 0, 1'b1, 3, 3, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 0, 1'b1, 1, 1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1, 1'b1, 2, 2, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 0, 1'b0, 0, 8, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1, 1'b0, 8, 8, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 2, 1'b0, 5, 5, 1'b1, 1'b0};

        reset = 1'b1; cfg_go = 1'b0; cfg_rev_w = 1'b0;
        in_valid = 1'b0; in_data = '0; tpu_done = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_in_ready", in_ready, 0);
        check_output("rst_write_addr", write_addr, 0);
        check_output("rst_write_data", write_data, 0);
        check_output("rst_write_en", write_en, 0);
        check_output("rst_tpu_start", tpu_start, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_err_timeout", err_timeout, 0);

        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h5A5A;
        tpu_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("idle_in_ready", in_ready, 0);
            check_output("idle_write_en", write_en, 0);
            check_output("idle_start", tpu_start, 0);
            check_output("idle_done", done, 0);
        end
        in_valid = 1'b0;
        tpu_done = 1'b0;

        for (int i = 0; i < 6; i++)
            apply_stimulus(vecs[i]);

        for (int i = 0; i < 20; i++) begin
            rv.rev       = 1'($urandom_range(0, 1));
            rv.gap       = 2;
            rv.fixed     = 1'b0;
            rv.done_at   = int'($urandom_range(0, 10));
            rv.exp_done  = (rv.done_at >= 1) && (rv.done_at <= TIMEOUT);
            rv.exp_start = rv.exp_done ? rv.done_at : TIMEOUT;
            rv.exp_to    = !rv.exp_done;
            apply_stimulus(rv);
        end

        @(negedge clk);
        cfg_go = 1'b1;
        cfg_rev_w = 1'b0;
        @(negedge clk);
        cfg_go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = DATA_W'(16'hA0 + i);
            @(negedge clk);
        end
        check_output("pre_reset_wen", write_en, 1);
        check_output("pre_reset_addr", write_addr, DATA_BASE + 2);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check_output("mid_rst_write_en", write_en, 0);
        check_output("mid_rst_in_ready", in_ready, 0);
        check_output("mid_rst_busy", busy, 0);
        check_output("mid_rst_addr", write_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
